axi_rd_bridge: RTL and testbench

- AXI-side responder for the cache read-request interface: accepts one line/word request (`rd_req`/`rd_type`/`rd_addr`), issues one AXI4 INCR read burst, and packs the 32-bit R beats into a 512-bit return buffer.
- Sits between the instruction-side prefetcher and the AXI crossbar.
- Signals `ret_half` once the low 256 bits of a 512-bit fetch are valid, so the cache can restart early.

---
 rtl/cache_axi_pkg.sv | 39 +++
 rtl/axi_rd_bridge.sv | 125 ++++++++++++
 tb/tb_axi_rd_bridge.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache-side AXI read bridge.
package cache_axi_pkg;

    // Request types on the cache read-request interface
    localparam logic [1:0] RD_TYPE_WORD  = 2'b00;
    localparam logic [1:0] RD_TYPE_LINE  = 2'b01;
    localparam logic [1:0] RD_TYPE_DLINE = 2'b10;
    localparam logic [1:0] RD_TYPE_RSVD  = 2'b11;

    // Fixed AXI burst attributes: 4-byte beats, incrementing bursts
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RET  = 2'd3
    } bridge_state_t;

    // arlen (beats - 1) for each request type
    function automatic logic [7:0] burst_len(input logic [1:0] t);
        case (t)
            RD_TYPE_LINE:  return 8'd7;
            RD_TYPE_DLINE: return 8'd15;
            default:       return 8'd0;
        endcase
    endfunction

    // Align the request address to the natural size of the transfer
    function automatic logic [31:0] align_addr(input logic [1:0] t, input logic [31:0] a);
        case (t)
            RD_TYPE_LINE:  return {a[31:5], 5'b0};
            RD_TYPE_DLINE: return {a[31:6], 6'b0};
            default:       return {a[31:2], 2'b0};
        endcase
    endfunction

endpackage

// File: rtl/axi_rd_bridge.sv
// Single-outstanding AXI4 read bridge: one cache request becomes one INCR
// burst whose 32-bit beats are packed into a 512-bit return buffer.
module axi_rd_bridge
    import cache_axi_pkg::*;
#(
    parameter logic [3:0] ID = 4'd0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [1:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [511:0] ret_data,
    output logic         ret_half,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    bridge_state_t r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_araddr;
    logic [7:0]    r_arlen;
    logic          r_is_dline;
    logic [511:0]  r_ret_data;
    logic          r_arvalid;
    logic          r_rready;
    logic          r_ret_valid;
    logic          r_ret_half;
    logic          r_rd_rdy;

    // Completion is counted against arlen, so the R-channel ID, response
    // and last flag carry no information the bridge needs.
    logic w_unused;
    assign w_unused = ^{rid, rresp, rlast};

    logic w_last_beat;
    assign w_last_beat = ({4'b0, r_cnt} == r_arlen);

    // Request/burst FSM with all handshake and return outputs registered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_araddr    <= 32'd0;
            r_arlen     <= 8'd0;
            r_is_dline  <= 1'b0;
            r_ret_data  <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_ret_valid <= 1'b0;
            r_ret_half  <= 1'b0;
            r_rd_rdy    <= 1'b1;
        end else begin
            r_ret_valid <= 1'b0;
            r_ret_half  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Reserved type is consumed silently; the bridge stays idle
                    if (rd_req && rd_type != RD_TYPE_RSVD) begin
                        r_araddr   <= align_addr(rd_type, rd_addr);
                        r_arlen    <= burst_len(rd_type);
                        r_is_dline <= (rd_type == RD_TYPE_DLINE);
                        r_ret_data <= '0;
                        r_arvalid  <= 1'b1;
                        r_rd_rdy   <= 1'b0;
                        r_state    <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        r_ret_data[{r_cnt, 5'b0} +: 32] <= rdata;
                        r_cnt <= r_cnt + 4'd1;
                        // Low half of a double line is complete: early restart
                        if (r_is_dline && r_cnt == 4'd7)
                            r_ret_half <= 1'b1;
                        if (w_last_beat) begin
                            r_rready    <= 1'b0;
                            r_ret_valid <= 1'b1;
                            r_state     <= RET;
                        end
                    end
                end
                RET: begin
                    r_cnt    <= 4'd0;
                    r_rd_rdy <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_rdy    = r_rd_rdy;
    assign ret_valid = r_ret_valid;
    assign ret_data  = r_ret_data;
    assign ret_half  = r_ret_half;
    assign arid      = ID;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = AXI_SIZE_4B;
    assign arburst   = AXI_BURST_INCR;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;

endmodule

// File: tb/tb_axi_rd_bridge.sv
// Scoreboard bench for axi_rd_bridge with a small AXI read-slave model.
module tb_axi_rd_bridge;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [1:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [511:0] ret_data;
    logic         ret_half;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    always #5 clk = ~clk;

    axi_rd_bridge #(.ID(4'd0)) dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data), .ret_half(ret_half),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        logic [511:0] data;
        bit           half;
        bit           do_lat;
        int           nb;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
    } ar_t;

    exp_t        sb_q[$];
    ar_t         ar_q[$];
    logic [31:0] beat_q[$];
    int          req_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int half_cnt = 0;
    int half_seen = 0;
    int ar_seen = 0;

    int ar_stall = 0;
    int ar_cnt = 0;
    bit r_gap = 0;
    bit phase = 0;
    bit hs_r = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mkdata(input int nb, input logic [31:0] base);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < nb; i++) d[32*i +: 32] = base + i;
        return d;
    endfunction

    // AXI read slave: arready after ar_stall cycles of arvalid, beats from beat_q
    initial begin
        arready = 0; rvalid = 0; rdata = 0; rid = 0; rresp = 0; rlast = 0;
        forever begin
            @(negedge clk);
            hs_r = rvalid && rready;
            @(posedge clk);
            #1;
            if (!resetn) begin
                arready = 0; rvalid = 0; ar_cnt = 0; hs_r = 0;
            end else begin
                if (hs_r && beat_q.size() > 0) void'(beat_q.pop_front());
                if (arvalid) begin
                    arready = (ar_cnt >= ar_stall);
                    ar_cnt++;
                end else begin
                    arready = 0;
                    ar_cnt = 0;
                end
                phase = ~phase;
                rvalid = rready && (beat_q.size() > 0) && (!r_gap || phase);
                rdata  = (beat_q.size() > 0) ? beat_q[0] : 32'h0;
                rlast  = rvalid && (beat_q.size() == 1);
            end
        end
    end

    // Output monitor: AR checks, scoreboard pop on ret_valid, ret_half checks
    always @(negedge clk) begin
        cyc++;
        if (resetn) begin
            if (rd_req && rd_rdy && rd_type != 2'b11) req_q.push_back(cyc);
            if (arvalid || rready) chk("rd_rdy_busy", rd_rdy, 1'b0);
            if (arvalid) begin
                if (ar_q.size() == 0) chk("ar_unexpected", 1'b1, 1'b0);
                else begin
                    chk("araddr", araddr, ar_q[0].a);
                    chk("arlen", arlen, ar_q[0].l);
                    if (arready) begin
                        chk("ar_attr", {arid, arsize, arburst}, {4'd0, 3'b010, 2'b01});
                        void'(ar_q.pop_front());
                        ar_seen++;
                    end
                end
            end
            if (ret_half) begin
                half_cnt++;
                half_seen++;
                chk("half_not_with_valid", ret_valid, 1'b0);
                if (sb_q.size() == 0) chk("half_unexpected", 1'b1, 1'b0);
                else begin
                    chk("half_allowed", 1'b1, sb_q[0].half);
                    chk("half_data", ret_data, {256'h0, sb_q[0].data[255:0]});
                    if (sb_q[0].do_lat && req_q.size() > 0)
                        chk("half_lat", cyc - req_q[0] + 1, 11);
                end
            end
            if (ret_valid) begin
                valid_cnt++;
                chk("rd_rdy_at_ret", rd_rdy, 1'b0);
                if (sb_q.size() == 0) chk("ret_unexpected", 1'b1, 1'b0);
                else begin
                    exp_t e;
                    int rq;
                    e = sb_q.pop_front();
                    rq = (req_q.size() > 0) ? req_q.pop_front() : -1000;
                    chk("ret_data", ret_data, e.data);
                    chk("half_count", half_seen, e.half ? 1 : 0);
                    if (e.do_lat) chk("ret_lat", cyc - rq + 1, e.nb + 3);
                end
                half_seen = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request (called just after a rising edge), holding until taken
    task automatic issue(input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] base, input bit do_lat);
        int nb;
        int k;
        exp_t e;
        ar_t  r;
        nb = (t == 2'b00) ? 1 : (t == 2'b01) ? 8 : 16;
        if (t != 2'b11) begin
            for (int i = 0; i < nb; i++) beat_q.push_back(base + i);
            e.data = mkdata(nb, base);
            e.half = (t == 2'b10);
            e.do_lat = do_lat;
            e.nb = nb;
            sb_q.push_back(e);
            r.a = (t == 2'b00) ? {a[31:2], 2'b0} : (t == 2'b01) ? {a[31:5], 5'b0} : {a[31:6], 6'b0};
            r.l = nb - 1;
            ar_q.push_back(r);
        end
        rd_req = 1; rd_type = t; rd_addr = a;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (rd_rdy) break;
            k++;
        end
        if (k >= 50) chk("req_accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rd_req = 0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (valid_cnt < target && k < budget) begin
            step(1);
            k++;
        end
        if (valid_cnt < target) chk("ret_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int v0;
        int h0;
        int k;
        resetn = 0; rd_req = 0; rd_type = 0; rd_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_rdy", rd_rdy, 1'b1);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_ret_valid", ret_valid, 1'b0);
        chk("rst_ret_half", ret_half, 1'b0);
        chk("rst_ret_data", ret_data, 512'h0);
        @(posedge clk);
        #1;
        resetn = 1;
        step(1);

        // Line fetch, immediate slave
        issue(2'b01, 32'h1FC0_0014, 32'h0, 1);
        wait_done(1, 100);
        chk("hold_line", ret_data, mkdata(8, 32'h0));
        chk("no_half_line", half_cnt, 0);

        // Double line fetch with early restart
        issue(2'b10, 32'h8000_0078, 32'h100, 1);
        wait_done(2, 100);
        chk("half_cnt_dline", half_cnt, 1);
        chk("top_word", ret_data[511:480], 32'h10F);

        // Single word
        issue(2'b00, 32'h0000_1003, 32'hDEAD_BEEF, 1);
        wait_done(3, 100);
        chk("hold_word", ret_data, {480'h0, 32'hDEAD_BEEF});

        // AR stall plus gapped R beats
        ar_stall = 5; r_gap = 1;
        issue(2'b01, 32'h0000_2044, 32'hA0, 0);
        wait_done(4, 200);
        chk("ret_once_stall", valid_cnt, 4);
        chk("rd_rdy_idle", rd_rdy, 1'b1);
        ar_stall = 0; r_gap = 0;

        // Reserved type is dropped
        v0 = valid_cnt; k = ar_seen;
        issue(2'b11, 32'h0000_3000, 32'h0, 0);
        step(6);
        chk("rsvd_no_ar", ar_seen, k);
        chk("rsvd_no_ret", valid_cnt, v0);
        chk("rsvd_rd_rdy", rd_rdy, 1'b1);

        // Reset after beat 3 of a double line
        v0 = valid_cnt; h0 = half_cnt;
        issue(2'b10, 32'h4000_0000, 32'h300, 0);
        k = 0;
        while (beat_q.size() > 12 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("beat3_timeout", 1'b0, 1'b1);
        resetn = 0;
        #1;
        chk("abort_rd_rdy", rd_rdy, 1'b1);
        chk("abort_arvalid", arvalid, 1'b0);
        chk("abort_rready", rready, 1'b0);
        chk("abort_ret_data", ret_data, 512'h0);
        beat_q.delete(); sb_q.delete(); ar_q.delete(); req_q.delete();
        half_seen = 0;
        step(2);
        resetn = 1;
        step(20);
        chk("abort_no_ret", valid_cnt, v0);
        chk("abort_no_half", half_cnt, h0);
        issue(2'b01, 32'h1234_5678, 32'h200, 1);
        wait_done(v0 + 1, 100);
        chk("post_rst_data", ret_data, mkdata(8, 32'h200));

        // Back-to-back: second request raised in the ret_valid cycle
        v0 = valid_cnt;
        issue(2'b00, 32'h0000_0003, 32'h1111_1111, 1);
        step(2);
        issue(2'b00, 32'h0000_0008, 32'h2222_2222, 1);
        wait_done(v0 + 2, 100);
        chk("b2b_data", ret_data, {480'h0, 32'h2222_2222});
        chk("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
